pipe_addsub: RTL and testbench
==============================

// Module: pipe_addsub
// PURPOSE
//  Pipelined, parametrised WIDTH-bit adder/subtractor with signed-saturation mode and ALU flags.
//  Operands are split into STAGES equal slices; each pipeline stage adds one slice and
//  registers the carry, so the clock period is set by a WIDTH/STAGES-bit ripple, not WIDTH.
//  Sits in the CPU execute path and accepts one operation per cycle.
//  Uses a valid/ready handshake on both sides.
// PARAMETERS
//  WIDTH   16  operand/result width in bits; must be divisible by STAGES
//  STAGES  4   pipeline depth = latency in cycles; 1..WIDTH
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  flush      in   1      synchronous: kill all in-flight ops
//  in_valid   in   1      operation offered
//  in_ready   out  1      operation accepted when in_valid & in_ready
//  op         in   2      00 ADD, 01 SUB (A-B), 10 ADDC (A+B+cin), 11 SADD (saturating signed add)
//  a, b       in   WIDTH  operands
//  cin        in   1      carry-in; used only by ADDC
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts when out_valid & out_ready
//  result     out  WIDTH  sum/difference (saturated when op=SADD)
//  cout       out  1      carry out of MSB; for SUB, 1 = no borrow
//  ovf        out  1      signed overflow of the unsaturated result
//  zero       out  1      result == 0, after saturation
// BEHAVIOUR
//  - Reset: all stage valids, out_valid, result, cout, ovf and zero are 0; in_ready is 1 once rst_n is high.
//  - Pipeline advances when adv = !out_valid | out_ready; in_ready = adv & !flush.
//  - SUB is computed as A + ~B + 1. ADD and SADD use carry-in 0. ADDC uses cin.
//  - Stage k (0..STAGES-1) adds bits [k*S +: S], with S = WIDTH/STAGES, using the carry
//    registered from stage k-1. Upper operand slices are carried forward unchanged; lower
//    result slices are skewed through.
//  - Latency is exactly STAGES cycles from acceptance to out_valid with no stall.
//  - Throughput is 1 op per cycle.
//  - ovf = carry into MSB ^ carry out of MSB, computed in the final stage.
//  - SADD with ovf=1 gives result 0x7F..F if a is non-negative, else 0x80..0.
//    ovf still reports 1. cout is the raw carry.
//  - Stall (out_valid & !out_ready): every stage holds. result, cout, ovf and zero stay
//    bit-stable until the handshake completes. No op is dropped or duplicated.
//  - flush: all stage valids and out_valid clear on the next edge. A same-cycle in_valid is
//    not accepted (in_ready=0). flush beats out_ready: a result offered in that cycle counts
//    as discarded, even if out_ready=1.
//  - Async reset mid-operation: all in-flight ops are lost and out_valid=0 immediately.
//    No stale output appears after reset is released.
//  - STAGES=1: a single registered WIDTH-bit adder with 1-cycle latency and the same handshake.
//  - Arithmetic is modulo 2^WIDTH. Flags are defined only while out_valid=1.
// STRUCTURE
//  - Shared include pipe_addsub_defs.vh: OP_ADD/OP_SUB/OP_ADDC/OP_SADD encodings, reused by
//    the ALU decoder.
//  - Sub-module addsub_slice #(S): combinational S-bit ripple adder made of 1-bit full-adder
//    cells. Outputs: sum, carry out, and carry into its MSB (for ovf).
//  - Top module: generate loop of STAGES slice instances plus stage registers, valid chain,
//    saturation/flag logic and the handshake.
// TESTING (WIDTH=16, STAGES=4 unless stated)
//  - ADD 0x7FFF+0x0001: result 0x8000, ovf=1, cout=0 after 4 cycles.
//    Same operands with SADD: result 0x7FFF, ovf=1, zero=0.
//  - SUB 0x0000-0x0001: 0xFFFF, cout=0, ovf=0. SUB 0x1234-0x1234: 0x0000, cout=1, zero=1.
//  - Full carry ripple: ADDC 0xFFFF+0x0000, cin=1: result 0x0000, cout=1, zero=1.
//    ADD 0x0FFF+0x0001: result 0x1000.
//  - 32 back-to-back random ops with out_ready random 50%: results match the scoreboard in
//    order, and outputs are stable while stalled.
//  - 3 ops in flight, then rst_n=0 for 1 cycle: out_valid=0 during reset and no result
//    emerges afterwards.
//    Repeat with flush + in_valid in the same cycle: that op is never output.
//  - STAGES=1 and STAGES=16 builds: ADD 0x8000+0x8000 gives 0x0000, cout=1, ovf=1, with
//    latency 1 and 16 respectively.

Source files
------------

// File: rtl/pipe_addsub_pkg.sv
// Shared types, opcode encodings and bit-level helpers for the pipelined adder/subtractor.
package pipe_addsub_pkg;

    localparam int unsigned DEF_WIDTH  = 16;
    localparam int unsigned DEF_STAGES = 4;
    localparam int unsigned OP_W       = 2;

    // Opcode encodings, also consumed by the ALU decoder
    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ADDC = 2'b10,
        OP_SADD = 2'b11
    } opT;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } flagsT;

    // Carry injected into the least-significant slice
    function automatic logic carryIn(input opT op, input logic cin);
        case (op)
            OP_SUB:  return 1'b1;
            OP_ADDC: return cin;
            default: return 1'b0;
        endcase
    endfunction

    // One full-adder cell: returns {carry, sum}
    function automatic logic [1:0] fullAdd(input logic x, input logic y, input logic c);
        return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
    endfunction

endpackage

// File: rtl/pipe_addsub_if.sv
// Operation/result handshake bundle between the execute stage and the adder pipeline.
interface pipe_addsub_if
    import pipe_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) ();

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    opT               op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output flush, in_valid, op, a, b, cin, out_ready,
        input  in_ready, out_valid, result, cout, ovf, zero
    );

    modport slave (
        input  flush, in_valid, op, a, b, cin, out_ready,
        output in_ready, out_valid, result, cout, ovf, zero
    );

endinterface

// File: rtl/pipe_addsub_slice.sv
// Combinational S-bit ripple adder built from full-adder cells; also exposes the carry
// into its MSB so the final stage can derive signed overflow.
module pipe_addsub_slice
    import pipe_addsub_pkg::*;
#(
    parameter int unsigned S = 4
) (
    input  logic [S-1:0] a,
    input  logic [S-1:0] b,
    input  logic         ci,
    output logic [S-1:0] sum,
    output logic         co,
    output logic         cMsb
);

    logic [S:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = ci;
        for (int unsigned i = 0; i < S; i++) begin
            {carry[i+1], sum[i]} = fullAdd(a[i], b[i], carry[i]);
        end
    end

    assign co   = carry[S];
    assign cMsb = carry[S-1];

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit add/sub: one S-bit slice per stage with a registered carry chain,
// signed saturation and flags in the last stage, valid/ready handshake on both sides.
module pipe_addsub
    import pipe_addsub_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned STAGES = DEF_STAGES
) (
    input  logic           clk,
    input  logic           rst_n,
    pipe_addsub_if.slave   bus
);

    localparam int unsigned S    = WIDTH / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    if ((WIDTH % STAGES) != 0 || STAGES == 0) begin : gBadCfg
        $error("pipe_addsub: WIDTH must be a non-zero multiple of STAGES");
    end

    logic adv;
    logic accept;
    logic outValid;

    // Operands seen by each stage: bus for stage 0, previous stage register otherwise
    logic [WIDTH-1:0] aIn     [STAGES];
    logic [WIDTH-1:0] bIn     [STAGES];
    logic [WIDTH-1:0] sumIn   [STAGES];
    logic [WIDTH-1:0] sumNext [STAGES];
    logic             cIn     [STAGES];
    logic             vIn     [STAGES];
    opT               opIn    [STAGES];

    logic [S-1:0]     sliceSum  [STAGES];
    logic             sliceCo   [STAGES];
    logic             sliceCMsb [STAGES];

    logic [WIDTH-1:0] aQ   [STAGES];
    logic [WIDTH-1:0] bQ   [STAGES];
    logic [WIDTH-1:0] sumQ [STAGES];
    logic             cQ   [STAGES];
    logic             vldQ [STAGES];
    opT               opQ  [STAGES];

    logic [WIDTH-1:0] resQ;
    flagsT            flagsQ;

    logic             rawOvf;
    logic [WIDTH-1:0] satRes;
    logic [WIDTH-1:0] minNeg;
    logic [WIDTH-1:0] maxPos;

    // Handshake: flush blocks acceptance even when the pipe could advance
    assign outValid     = vldQ[LAST];
    assign adv          = !outValid || bus.out_ready;
    assign bus.in_ready = adv && !bus.flush;
    assign accept       = bus.in_valid && bus.in_ready;

    for (genvar k = 0; k < STAGES; k++) begin : gStage
        if (k == 0) begin : gHead
            // SUB is folded into A + ~B + 1 before entering the chain
            assign aIn[0]   = bus.a;
            assign bIn[0]   = (bus.op == OP_SUB) ? ~bus.b : bus.b;
            assign cIn[0]   = carryIn(bus.op, bus.cin);
            assign sumIn[0] = '0;
            assign opIn[0]  = bus.op;
            assign vIn[0]   = accept;
        end else begin : gBody
            assign aIn[k]   = aQ[k-1];
            assign bIn[k]   = bQ[k-1];
            assign cIn[k]   = cQ[k-1];
            assign sumIn[k] = sumQ[k-1];
            assign opIn[k]  = opQ[k-1];
            assign vIn[k]   = vldQ[k-1];
        end

        pipe_addsub_slice #(.S(S)) uSlice (
            .a    (aIn[k][k*S +: S]),
            .b    (bIn[k][k*S +: S]),
            .ci   (cIn[k]),
            .sum  (sliceSum[k]),
            .co   (sliceCo[k]),
            .cMsb (sliceCMsb[k])
        );

        // Merge this stage's slice into the skewed partial result
        assign sumNext[k] = (sumIn[k] & ~(WIDTH'({S{1'b1}}) << (k*S)))
                          | (WIDTH'(sliceSum[k]) << (k*S));
    end

    assign minNeg = WIDTH'(1) << (WIDTH - 1);
    assign maxPos = ~minNeg;
    assign rawOvf = sliceCMsb[LAST] ^ sliceCo[LAST];

    // Saturate toward the sign of a when a signed add overflows
    always_comb begin
        satRes = sumNext[LAST];
        if (opIn[LAST] == OP_SADD && rawOvf) begin
            satRes = aIn[LAST][WIDTH-1] ? minNeg : maxPos;
        end
    end

    // Stage registers: all hold on stall, valids drop on flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                vldQ[k] <= 1'b0;
                aQ[k]   <= '0;
                bQ[k]   <= '0;
                sumQ[k] <= '0;
                cQ[k]   <= 1'b0;
                opQ[k]  <= OP_ADD;
            end
            resQ   <= '0;
            flagsQ <= '0;
        end else if (bus.flush) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                vldQ[k] <= 1'b0;
            end
        end else if (adv) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                vldQ[k] <= vIn[k];
                aQ[k]   <= aIn[k];
                bQ[k]   <= bIn[k];
                sumQ[k] <= sumNext[k];
                cQ[k]   <= sliceCo[k];
                opQ[k]  <= opIn[k];
            end
            resQ   <= satRes;
            flagsQ <= '{cout: sliceCo[LAST], ovf: rawOvf, zero: (satRes == '0)};
        end
    end

    assign bus.out_valid = outValid;
    assign bus.result    = resQ;
    assign bus.cout      = flagsQ.cout;
    assign bus.ovf       = flagsQ.ovf;
    assign bus.zero      = flagsQ.zero;

endmodule

// File: tb/tb_pipe_addsub.sv
// Scoreboard bench for pipe_addsub: 4-stage main instance plus 1- and 16-stage builds.
module tb_pipe_addsub;
    import pipe_addsub_pkg::*;

    localparam int unsigned W = 16;

    typedef struct packed {
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
        logic         zero;
    } expT;

    typedef struct {
        expT e;
        int  acc;
        bit  lat;
    } itemT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_addsub_if #(.WIDTH(W)) bus4 ();
    pipe_addsub_if #(.WIDTH(W)) bus1 ();
    pipe_addsub_if #(.WIDTH(W)) bus16 ();

    pipe_addsub #(.WIDTH(W), .STAGES(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
    pipe_addsub #(.WIDTH(W), .STAGES(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    pipe_addsub #(.WIDTH(W), .STAGES(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));

    int   nChecks = 0;
    int   nFail   = 0;
    int   cycle   = 0;
    bit   randReady = 1'b0;
    itemT sbQ[$];
    itemT popped;
    bit   stallPrev = 1'b0;
    logic [W-1:0] heldRes;
    logic [2:0]   heldFlags;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: full-width integer arithmetic, independent of slicing
    function automatic expT model(input opT op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin);
        expT          r;
        logic [W-1:0] bb;
        logic         c;
        logic [W:0]   wide;
        int           sAll;
        bb   = (op == OP_SUB) ? ~b : b;
        c    = (op == OP_SUB) ? 1'b1 : ((op == OP_ADDC) ? cin : 1'b0);
        wide = {1'b0, a} + {1'b0, bb} + (W+1)'(c);
        sAll = int'($signed(a)) + int'($signed(bb)) + int'(c);
        r.cout = wide[W];
        r.ovf  = (sAll > 32767) || (sAll < -32768);
        r.res  = wide[W-1:0];
        if (op == OP_SADD && r.ovf) r.res = a[W-1] ? 16'h8000 : 16'h7FFF;
        r.zero = (r.res == '0);
        return r;
    endfunction

    always @(posedge clk) cycle <= cycle + 1;

    always @(posedge clk) begin
        #1;
        if (randReady) bus4.out_ready = 1'($urandom_range(0, 1));
    end

    // Output monitor: pop on handshake, verify hold while stalled
    always @(negedge clk) begin
        if (stallPrev && bus4.out_valid) begin
            checkVal("holdResult", 32'(bus4.result), 32'(heldRes));
            checkVal("holdFlags", 32'({bus4.cout, bus4.ovf, bus4.zero}), 32'(heldFlags));
        end
        stallPrev = 1'b0;
        if (rst_n && bus4.out_valid && !bus4.flush) begin
            if (!bus4.out_ready) begin
                stallPrev = 1'b1;
                heldRes   = bus4.result;
                heldFlags = {bus4.cout, bus4.ovf, bus4.zero};
            end else if (sbQ.size() == 0) begin
                checkVal("spuriousOut", 32'(bus4.out_valid), 32'd0);
            end else begin
                popped = sbQ.pop_front();
                checkVal("result", 32'(bus4.result), 32'(popped.e.res));
                checkVal("cout", 32'(bus4.cout), 32'(popped.e.cout));
                checkVal("ovf", 32'(bus4.ovf), 32'(popped.e.ovf));
                checkVal("zero", 32'(bus4.zero), 32'(popped.e.zero));
                if (popped.lat) checkVal("latency4", 32'(cycle - popped.acc), 32'd4);
            end
        end
    end

    task automatic sendOp(input opT op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input bit lat);
        int waitCnt = 0;
        bit done = 1'b0;
        bus4.in_valid = 1'b1;
        bus4.op  = op;
        bus4.a   = a;
        bus4.b   = b;
        bus4.cin = cin;
        while (!done) begin
            @(negedge clk);
            if (bus4.in_ready) begin
                sbQ.push_back('{e: model(op, a, b, cin), acc: cycle, lat: lat});
                done = 1'b1;
            end else if (++waitCnt > 200) begin
                checkVal("acceptTimeout", 32'd0, 32'd1);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus4.in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sbQ.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkVal("drained", 32'(sbQ.size()), 32'd0);
    endtask

    initial begin
        int lat1 = 0;
        int lat16 = 0;
        logic [W-1:0] res1 = '0;
        logic [W-1:0] res16 = '0;
        logic [2:0] fl1 = '0;
        logic [2:0] fl16 = '0;
        int n;

        bus4.flush = 0;  bus4.in_valid = 0;  bus4.op = OP_ADD;  bus4.a = 0;  bus4.b = 0;
        bus4.cin = 0;    bus4.out_ready = 1;
        bus1.flush = 0;  bus1.in_valid = 0;  bus1.op = OP_ADD;  bus1.a = 0;  bus1.b = 0;
        bus1.cin = 0;    bus1.out_ready = 1;
        bus16.flush = 0; bus16.in_valid = 0; bus16.op = OP_ADD; bus16.a = 0; bus16.b = 0;
        bus16.cin = 0;   bus16.out_ready = 1;

        repeat (3) @(posedge clk);
        #1;
        checkVal("rstOutValid", 32'(bus4.out_valid), 32'd0);
        checkVal("rstResult", 32'(bus4.result), 32'd0);
        checkVal("rstFlags", 32'({bus4.cout, bus4.ovf, bus4.zero}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkVal("rstInReady", 32'(bus4.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed corner cases, back-to-back, no stall
        sendOp(OP_ADD,  16'h7FFF, 16'h0001, 1'b0, 1'b1);
        sendOp(OP_SADD, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
        sendOp(OP_SUB,  16'h0000, 16'h0001, 1'b0, 1'b1);
        sendOp(OP_SUB,  16'h1234, 16'h1234, 1'b0, 1'b1);
        sendOp(OP_ADDC, 16'hFFFF, 16'h0000, 1'b1, 1'b1);
        sendOp(OP_ADD,  16'h0FFF, 16'h0001, 1'b0, 1'b1);
        sendOp(OP_SADD, 16'h8000, 16'hFFFF, 1'b0, 1'b1);
        sendOp(OP_ADD,  16'h8000, 16'h8000, 1'b0, 1'b1);
        sendOp(OP_ADDC, 16'h00FF, 16'h0000, 1'b0, 1'b1);
        waitDrain();

        // Random traffic against a randomly stalling consumer
        randReady = 1'b1;
        for (int i = 0; i < 32; i++) begin
            sendOp(opT'($urandom_range(0, 3)), W'($urandom), W'($urandom),
                   1'($urandom_range(0, 1)), 1'b0);
        end
        waitDrain();
        randReady = 1'b0;
        @(posedge clk);
        #1;
        bus4.out_ready = 1'b1;

        // Async reset with three ops in flight
        sendOp(OP_ADD, 16'h0001, 16'h0002, 1'b0, 1'b0);
        sendOp(OP_ADD, 16'h0003, 16'h0004, 1'b0, 1'b0);
        sendOp(OP_ADD, 16'h0005, 16'h0006, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkVal("outValidInReset", 32'(bus4.out_valid), 32'd0);
        @(posedge clk);
        #1;
        checkVal("outValidInReset2", 32'(bus4.out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sbQ.delete();
        repeat (10) begin
            @(negedge clk);
            checkVal("noStaleAfterReset", 32'(bus4.out_valid), 32'd0);
        end

        // Flush with a stalled result and a same-cycle offer
        @(posedge clk);
        #1;
        bus4.out_ready = 1'b0;
        sendOp(OP_SUB, 16'h0010, 16'h0001, 1'b0, 1'b0);
        sendOp(OP_SUB, 16'h0020, 16'h0002, 1'b0, 1'b0);
        sendOp(OP_SUB, 16'h0030, 16'h0003, 1'b0, 1'b0);
        n = 0;
        while (!bus4.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkVal("flushSetupValid", 32'(bus4.out_valid), 32'd1);
        @(posedge clk);
        #1;
        bus4.flush     = 1'b1;
        bus4.in_valid  = 1'b1;
        bus4.op        = OP_ADD;
        bus4.a         = 16'hABCD;
        bus4.b         = 16'h0001;
        bus4.out_ready = 1'b1;
        #1;
        checkVal("inReadyDuringFlush", 32'(bus4.in_ready), 32'd0);
        @(posedge clk);
        #1;
        bus4.flush    = 1'b0;
        bus4.in_valid = 1'b0;
        sbQ.delete();
        checkVal("outValidAfterFlush", 32'(bus4.out_valid), 32'd0);
        repeat (10) begin
            @(negedge clk);
            checkVal("noOutAfterFlush", 32'(bus4.out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        sendOp(OP_ADD, 16'h1111, 16'h2222, 1'b0, 1'b1);
        waitDrain();

        // Latency of the 1-stage and 16-stage builds
        bus1.in_valid = 1'b1;  bus1.op = OP_ADD;  bus1.a = 16'h8000;  bus1.b = 16'h8000;
        bus16.in_valid = 1'b1; bus16.op = OP_ADD; bus16.a = 16'h8000; bus16.b = 16'h8000;
        #1;
        checkVal("inReady1", 32'(bus1.in_ready), 32'd1);
        checkVal("inReady16", 32'(bus16.in_ready), 32'd1);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 1) begin
                bus1.in_valid  = 1'b0;
                bus16.in_valid = 1'b0;
            end
            if (lat1 == 0 && bus1.out_valid) begin
                lat1 = cyc;
                res1 = bus1.result;
                fl1  = {bus1.cout, bus1.ovf, bus1.zero};
            end
            if (lat16 == 0 && bus16.out_valid) begin
                lat16 = cyc;
                res16 = bus16.result;
                fl16  = {bus16.cout, bus16.ovf, bus16.zero};
            end
        end
        checkVal("latency1", 32'(lat1), 32'd1);
        checkVal("result1", 32'(res1), 32'h0000);
        checkVal("flags1", 32'(fl1), 32'b111);
        checkVal("latency16", 32'(lat16), 32'd16);
        checkVal("result16", 32'(res16), 32'h0000);
        checkVal("flags16", 32'(fl16), 32'b111);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
